// File: rtl/cr_error_codes.sv
// Zipline error codes carried alongside decompressor data.
package cr_error_codes;

  typedef enum logic [7:0] {
    NO_ERRORS        = 8'h00,
    HD_BHP_ILLEGAL   = 8'h11,
    HD_BHP_BAD_SIZE  = 8'h12,
    HD_LZ_DIST_RANGE = 8'h20
  } zipline_error_e;

endpackage

// File: rtl/cr_xp10_decompPKG.sv
// Shared XP10 decompressor types: narrow beat bundle and
// the lanes-to-narrow FSM state encoding.
package cr_xp10_decompPKG;
  import cr_error_codes::*;

  localparam int NRW_W = 64;

  typedef struct packed {
    logic [NRW_W-1:0] data;
    logic [6:0]       numbits;
    logic             sob;
    logic             eob;
    logic             eof;
    zipline_error_e   error;
    logic             trace_bit;
    logic [27:0]      frame_bytes_in;
    logic             last_frame;
  } lanes_nrw_beat_t;

  typedef enum logic [1:0] {
    NRW_EMPTY,
    NRW_BEAT0,
    NRW_BEAT1
  } nrw_state_e;

endpackage

// File: rtl/cr_xp10_decomp_lanes_nrw.sv
// Splits one wide lane word into one or two narrow beats,
// holding the upper half until beat 0 is consumed.
module cr_xp10_decomp_lanes_nrw
  import cr_error_codes::*;
  import cr_xp10_decompPKG::*;
#(
  parameter int IN_W  = 128,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lanes_nrw_valid,
  input  logic [IN_W-1:0]  lanes_nrw_data,
  input  logic [7:0]       lanes_nrw_numbits,
  input  logic             lanes_nrw_sob,
  input  logic             lanes_nrw_eob,
  input  logic             lanes_nrw_eof,
  input  logic             lanes_nrw_trace_bit,
  input  logic             lanes_nrw_last_frame,
  input  logic [27:0]      lanes_nrw_frame_bytes_in,
  input  zipline_error_e   lanes_nrw_errcode,
  output logic             nrw_lanes_ready,
  output logic             nrw_dp_valid,
  output logic [OUT_W-1:0] nrw_dp_data,
  output logic [6:0]       nrw_dp_numbits,
  output logic             nrw_dp_sob,
  output logic             nrw_dp_eob,
  output logic             nrw_dp_eof,
  output logic             nrw_dp_trace_bit,
  output logic             nrw_dp_last_frame,
  output logic [27:0]      nrw_dp_frame_bytes_in,
  output zipline_error_e   nrw_dp_errcode,
  input  logic             dp_nrw_ready,
  output logic             output_stall_stb
);

  nrw_state_e      state_q;
  lanes_nrw_beat_t beat_q;
  lanes_nrw_beat_t b0_d;
  lanes_nrw_beat_t b1_d;
  logic            valid_q;
  logic            two_q;
  logic            stb_q;

  logic [OUT_W-1:0] hi_data_q;
  logic [6:0]       hi_nb_q;
  logic             hi_eob_q;
  logic             hi_eof_q;
  zipline_error_e   hi_err_q;

  logic       wide;
  logic [7:0] hi_nb_full;
  logic       last_beat;
  logic       accept;

  assign wide       = lanes_nrw_numbits > 8'd64;
  assign hi_nb_full = lanes_nrw_numbits - 8'd64;

  assign last_beat = (state_q == NRW_BEAT1) ||
                     ((state_q == NRW_BEAT0) && !two_q);

  assign nrw_lanes_ready = !rst &&
    ((state_q == NRW_EMPTY) || (last_beat && dp_nrw_ready));

  assign accept = lanes_nrw_valid && nrw_lanes_ready;

  always_comb begin
    b0_d                = '0;
    b0_d.data           = lanes_nrw_data[OUT_W-1:0];
    b0_d.numbits        = wide ? 7'd64 : lanes_nrw_numbits[6:0];
    b0_d.sob            = lanes_nrw_sob;
    b0_d.eob            = wide ? 1'b0 : lanes_nrw_eob;
    b0_d.eof            = wide ? 1'b0 : lanes_nrw_eof;
    b0_d.error          = wide ? NO_ERRORS : lanes_nrw_errcode;
    b0_d.trace_bit      = lanes_nrw_trace_bit;
    b0_d.frame_bytes_in = lanes_nrw_frame_bytes_in;
    b0_d.last_frame     = lanes_nrw_last_frame;
  end

  // Per-word fields come from beat 0, which is still presented.
  always_comb begin
    b1_d                = '0;
    b1_d.data           = hi_data_q;
    b1_d.numbits        = hi_nb_q;
    b1_d.sob            = 1'b0;
    b1_d.eob            = hi_eob_q;
    b1_d.eof            = hi_eof_q;
    b1_d.error          = hi_err_q;
    b1_d.trace_bit      = beat_q.trace_bit;
    b1_d.frame_bytes_in = beat_q.frame_bytes_in;
    b1_d.last_frame     = beat_q.last_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= NRW_EMPTY;
      valid_q   <= 1'b0;
      beat_q    <= '0;
      two_q     <= 1'b0;
      stb_q     <= 1'b0;
      hi_data_q <= '0;
      hi_nb_q   <= '0;
      hi_eob_q  <= 1'b0;
      hi_eof_q  <= 1'b0;
      hi_err_q  <= NO_ERRORS;
    end else begin
      stb_q <= valid_q && !dp_nrw_ready && beat_q.trace_bit;
      if (accept) begin
        state_q   <= NRW_BEAT0;
        valid_q   <= 1'b1;
        beat_q    <= b0_d;
        two_q     <= wide;
        hi_data_q <= lanes_nrw_data[IN_W-1:OUT_W];
        hi_nb_q   <= hi_nb_full[6:0];
        hi_eob_q  <= lanes_nrw_eob;
        hi_eof_q  <= lanes_nrw_eof;
        hi_err_q  <= lanes_nrw_errcode;
      end else if (valid_q && dp_nrw_ready) begin
        if (!last_beat) begin
          state_q <= NRW_BEAT1;
          beat_q  <= b1_d;
        end else begin
          state_q <= NRW_EMPTY;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign nrw_dp_valid          = valid_q;
  assign nrw_dp_data           = beat_q.data;
  assign nrw_dp_numbits        = beat_q.numbits;
  assign nrw_dp_sob            = beat_q.sob;
  assign nrw_dp_eob            = beat_q.eob;
  assign nrw_dp_eof            = beat_q.eof;
  assign nrw_dp_trace_bit      = beat_q.trace_bit;
  assign nrw_dp_last_frame     = beat_q.last_frame;
  assign nrw_dp_frame_bytes_in = beat_q.frame_bytes_in;
  assign nrw_dp_errcode        = beat_q.error;
  assign output_stall_stb      = stb_q;

endmodule

// File: tb/tb_cr_xp10_decomp_lanes_nrw.sv
// Scoreboard bench for the lanes-to-narrow splitter:
// directed words push expected beats, a monitor pops them.
module tb_cr_xp10_decomp_lanes_nrw;
  import cr_error_codes::*;
  import cr_xp10_decompPKG::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           lanes_nrw_valid;
  logic [127:0]   lanes_nrw_data;
  logic [7:0]     lanes_nrw_numbits;
  logic           lanes_nrw_sob;
  logic           lanes_nrw_eob;
  logic           lanes_nrw_eof;
  logic           lanes_nrw_trace_bit;
  logic           lanes_nrw_last_frame;
  logic [27:0]    lanes_nrw_frame_bytes_in;
  zipline_error_e lanes_nrw_errcode;
  logic           nrw_lanes_ready;
  logic           nrw_dp_valid;
  logic [63:0]    nrw_dp_data;
  logic [6:0]     nrw_dp_numbits;
  logic           nrw_dp_sob;
  logic           nrw_dp_eob;
  logic           nrw_dp_eof;
  logic           nrw_dp_trace_bit;
  logic           nrw_dp_last_frame;
  logic [27:0]    nrw_dp_frame_bytes_in;
  zipline_error_e nrw_dp_errcode;
  logic           dp_nrw_ready;
  logic           output_stall_stb;

  always #5 clk = ~clk;

  cr_xp10_decomp_lanes_nrw #(.IN_W(128), .OUT_W(64)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .lanes_nrw_valid          (lanes_nrw_valid),
    .lanes_nrw_data           (lanes_nrw_data),
    .lanes_nrw_numbits        (lanes_nrw_numbits),
    .lanes_nrw_sob            (lanes_nrw_sob),
    .lanes_nrw_eob            (lanes_nrw_eob),
    .lanes_nrw_eof            (lanes_nrw_eof),
    .lanes_nrw_trace_bit      (lanes_nrw_trace_bit),
    .lanes_nrw_last_frame     (lanes_nrw_last_frame),
    .lanes_nrw_frame_bytes_in (lanes_nrw_frame_bytes_in),
    .lanes_nrw_errcode        (lanes_nrw_errcode),
    .nrw_lanes_ready          (nrw_lanes_ready),
    .nrw_dp_valid             (nrw_dp_valid),
    .nrw_dp_data              (nrw_dp_data),
    .nrw_dp_numbits           (nrw_dp_numbits),
    .nrw_dp_sob               (nrw_dp_sob),
    .nrw_dp_eob               (nrw_dp_eob),
    .nrw_dp_eof               (nrw_dp_eof),
    .nrw_dp_trace_bit         (nrw_dp_trace_bit),
    .nrw_dp_last_frame        (nrw_dp_last_frame),
    .nrw_dp_frame_bytes_in    (nrw_dp_frame_bytes_in),
    .nrw_dp_errcode           (nrw_dp_errcode),
    .dp_nrw_ready             (dp_nrw_ready),
    .output_stall_stb         (output_stall_stb)
  );

  lanes_nrw_beat_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic rand_rdy = 1'b0;
  logic chk_bubble = 1'b0;
  int   bubbles = 0;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic lanes_nrw_beat_t bt(
    input logic [63:0] d, input logic [6:0] nb,
    input logic sob, input logic eob, input logic eof,
    input zipline_error_e e, input logic tr,
    input logic [27:0] fb, input logic lf);
    lanes_nrw_beat_t b;
    b.data = d;
    b.numbits = nb;
    b.sob = sob;
    b.eob = eob;
    b.eof = eof;
    b.error = e;
    b.trace_bit = tr;
    b.frame_bytes_in = fb;
    b.last_frame = lf;
    return b;
  endfunction

  // Monitor: scoreboard pops, hold-while-stalled, stall strobe.
  lanes_nrw_beat_t got;
  lanes_nrw_beat_t prev;
  logic prev_stall = 1'b0;
  logic prev_rst = 1'b1;
  logic prev_cond = 1'b0;

  always @(negedge clk) begin
    got.data = nrw_dp_data;
    got.numbits = nrw_dp_numbits;
    got.sob = nrw_dp_sob;
    got.eob = nrw_dp_eob;
    got.eof = nrw_dp_eof;
    got.error = nrw_dp_errcode;
    got.trace_bit = nrw_dp_trace_bit;
    got.frame_bytes_in = nrw_dp_frame_bytes_in;
    got.last_frame = nrw_dp_last_frame;
    if (prev_stall) begin
      check("hold_valid", 128'(nrw_dp_valid), 128'(1'b1));
      check("hold_beat", 128'(got), 128'(prev));
    end
    check("stall_stb", 128'(output_stall_stb),
          128'(prev_rst ? 1'b0 : prev_cond));
    if (rst) check("rdy_in_rst", 128'(nrw_lanes_ready), 128'(1'b0));
    if (!rst && nrw_dp_valid && dp_nrw_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 128'(1'b1), 128'(1'b0));
      end else begin
        check("beat", 128'(got), 128'(exp_q.pop_front()));
      end
    end
    if (chk_bubble && dp_nrw_ready && !nrw_dp_valid) bubbles++;
    prev_cond = nrw_dp_valid && !dp_nrw_ready && nrw_dp_trace_bit;
    prev_stall = !rst && nrw_dp_valid && !dp_nrw_ready;
    prev = got;
    prev_rst = rst;
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) dp_nrw_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [127:0] d, input logic [7:0] nb,
                      input logic sob, input logic eob,
                      input logic eof, input zipline_error_e e,
                      input logic tr, input logic [27:0] fb,
                      input logic lf);
    int n;
    lanes_nrw_data = d;
    lanes_nrw_numbits = nb;
    lanes_nrw_sob = sob;
    lanes_nrw_eob = eob;
    lanes_nrw_eof = eof;
    lanes_nrw_errcode = e;
    lanes_nrw_trace_bit = tr;
    lanes_nrw_frame_bytes_in = fb;
    lanes_nrw_last_frame = lf;
    lanes_nrw_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!nrw_lanes_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 128'(1'b1), 128'(1'b0));
    @(posedge clk);
    #1;
    lanes_nrw_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'(0));
  endtask

  localparam logic [63:0] W1H = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] W1L = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W2L = 64'h0000_00FE_DCBA_9876;
  localparam logic [63:0] W3H = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] W3L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W5H = 64'h5555_5555_5555_5555;
  localparam logic [63:0] W5L = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] W6H = 64'h0000_0000_0000_0001;
  localparam logic [63:0] W6L = 64'hFEDC_BA98_7654_3210;

  task automatic w1();
    exp_q.push_back(bt(W1L, 7'd64, 1, 0, 0, NO_ERRORS, 0,
                       28'h100, 0));
    exp_q.push_back(bt(W1H, 7'd64, 0, 1, 0, NO_ERRORS, 0,
                       28'h100, 0));
    send({W1H, W1L}, 8'd128, 1, 1, 0, NO_ERRORS, 0, 28'h100, 0);
  endtask

  task automatic w2();
    exp_q.push_back(bt(W2L, 7'd40, 0, 0, 1, HD_BHP_ILLEGAL, 0,
                       28'h55, 0));
    send({64'hFFFF_0000_FFFF_0000, W2L}, 8'd40, 0, 0, 1,
         HD_BHP_ILLEGAL, 0, 28'h55, 0);
  endtask

  task automatic w3(input logic both);
    exp_q.push_back(bt(W3L, 7'd64, 1, 0, 0, NO_ERRORS, 1,
                       28'hABCDEF0, 1));
    if (both)
      exp_q.push_back(bt(W3H, 7'd36, 0, 1, 1, HD_BHP_ILLEGAL, 1,
                         28'hABCDEF0, 1));
    send({W3H, W3L}, 8'd100, 1, 1, 1, HD_BHP_ILLEGAL, 1,
         28'hABCDEF0, 1);
  endtask

  task automatic w4();
    exp_q.push_back(bt(64'h0, 7'd0, 0, 1, 1, NO_ERRORS, 0,
                       28'h7, 1));
    send(128'h0, 8'd0, 0, 1, 1, NO_ERRORS, 0, 28'h7, 1);
  endtask

  task automatic w5();
    exp_q.push_back(bt(W5L, 7'd64, 1, 1, 0, NO_ERRORS, 0,
                       28'h40, 0));
    send({W5H, W5L}, 8'd64, 1, 1, 0, NO_ERRORS, 0, 28'h40, 0);
  endtask

  task automatic w6();
    exp_q.push_back(bt(W6L, 7'd64, 1, 0, 0, NO_ERRORS, 1,
                       28'h1234, 0));
    exp_q.push_back(bt(W6H, 7'd1, 0, 0, 1, HD_BHP_BAD_SIZE, 1,
                       28'h1234, 0));
    send({W6H, W6L}, 8'd65, 1, 0, 1, HD_BHP_BAD_SIZE, 1,
         28'h1234, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    lanes_nrw_valid = 1'b0;
    lanes_nrw_data = '0;
    lanes_nrw_numbits = '0;
    lanes_nrw_sob = 1'b0;
    lanes_nrw_eob = 1'b0;
    lanes_nrw_eof = 1'b0;
    lanes_nrw_trace_bit = 1'b0;
    lanes_nrw_last_frame = 1'b0;
    lanes_nrw_frame_bytes_in = '0;
    lanes_nrw_errcode = NO_ERRORS;
    dp_nrw_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 128'(nrw_dp_valid), 128'(1'b0));
    check("rst_ready", 128'(nrw_lanes_ready), 128'(1'b0));
    check("rst_stb", 128'(output_stall_stb), 128'(1'b0));
    check("rst_data", 128'(nrw_dp_data), 128'(0));
    check("rst_numbits", 128'(nrw_dp_numbits), 128'(0));
    check("rst_err", 128'(nrw_dp_errcode), 128'(NO_ERRORS));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("empty_ready", 128'(nrw_lanes_ready), 128'(1'b1));
    @(posedge clk);
    #1;

    // back-to-back words with ready held high
    w1();
    check("latency", 128'(nrw_dp_valid), 128'(1'b1));
    chk_bubble = 1'b1;
    w2();
    w6();
    w5();
    drain();
    chk_bubble = 1'b0;
    check("no_bubble", 128'(bubbles), 128'(0));
    #1;

    // beat 1 stalled for three cycles with trace set
    w3(1'b1);
    @(posedge clk);
    #1;
    dp_nrw_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", 128'(nrw_lanes_ready), 128'(1'b0));
      check("stall_numbits", 128'(nrw_dp_numbits), 128'(36));
      if (i > 0)
        check("stall_stb_on", 128'(output_stall_stb), 128'(1'b1));
    end
    @(posedge clk);
    #1;
    dp_nrw_ready = 1'b1;
    drain();
    #1;

    w4();
    drain();
    #1;

    // mixed stream under random downstream ready
    rand_rdy = 1'b1;
    w1();
    w3(1'b1);
    w2();
    w4();
    w6();
    w5();
    drain();
    rand_rdy = 1'b0;
    #1;
    dp_nrw_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset while beat 1 is presented
    dp_nrw_ready = 1'b0;
    w3(1'b0);
    dp_nrw_ready = 1'b1;
    @(posedge clk);
    #1;
    dp_nrw_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 128'(nrw_dp_valid), 128'(1'b0));
    check("mid_rst_q", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
    dp_nrw_ready = 1'b1;
    w5();
    check("post_rst_valid", 128'(nrw_dp_valid), 128'(1'b1));
    check("post_rst_sob", 128'(nrw_dp_sob), 128'(1'b1));
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
